// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-stream output between N_INPUTS sources,
// with bursts of up to MAX_BURST beats and a per-source TLAST every TLAST_PERIOD beats.
//   state   | meaning
//   IDLE    | arbitrate among valid sources, starting after last_grant
//   GRANTED | accept beats from the granted source
module axi_stream_rr_arbiter #(
    parameter int N_INPUTS     = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int DEST_WIDTH   = 8,
    parameter int USER_WIDTH   = 8,
    parameter int TLAST_PERIOD = 1024,
    parameter int MAX_BURST    = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_INPUTS-1:0]                  stream_in_valid,
    output logic [N_INPUTS-1:0]                  stream_in_ready,
    input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  stream_in_data,
    input  logic [N_INPUTS-1:0][DEST_WIDTH-1:0]  stream_in_dest,
    input  logic [N_INPUTS-1:0][USER_WIDTH-1:0]  stream_in_user,
    output logic                                 stream_out_valid,
    input  logic                                 stream_out_ready,
    output logic [DATA_WIDTH-1:0]                stream_out_data,
    output logic [DEST_WIDTH-1:0]                stream_out_dest,
    output logic [USER_WIDTH-1:0]                stream_out_user,
    output logic                                 stream_out_last,
    output logic [$clog2(N_INPUTS)-1:0]          grant,
    output logic                                 grant_active
);

    localparam int GW = $clog2(N_INPUTS);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [GW-1:0]           rr_sel, cand;
    logic                    rr_found;
    logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
    logic [N_INPUTS-1:0][15:0] tlast_cnt_q;
    logic [15:0]             cur_cnt;
    logic                    accept_ok, handshake, tlast_hit;

    // Scan starts one past the last grant and wraps, so every source gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        cand     = last_grant_q;
        for (int i = 0; i < N_INPUTS; i++) begin
            cand = (cand == GW'(N_INPUTS - 1)) ? '0 : cand + 1'b1;
            if (!rr_found && stream_in_valid[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    // Ready is gated by reset so no source sees a handshake the register will discard.
    always_comb begin
        accept_ok       = ~stream_out_valid | stream_out_ready;
        stream_in_ready = '0;
        if (state_q == GRANTED && accept_ok && !reset)
            stream_in_ready[grant_q] = 1'b1;
        handshake = (state_q == GRANTED) && accept_ok && !reset && stream_in_valid[grant_q];
        cur_cnt   = tlast_cnt_q[grant_q];
        tlast_hit = (cur_cnt == 16'(TLAST_PERIOD - 1));
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d     = GRANTED;
                    grant_d     = rr_sel;
                    burst_cnt_d = '0;
                end
            end
            GRANTED: begin
                if (handshake)
                    burst_cnt_d = burst_cnt_q + 1'b1;
                if ((handshake && burst_cnt_q == BW'(MAX_BURST - 1)) || !stream_in_valid[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_INPUTS - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stream_out_valid <= 1'b0;
            stream_out_last  <= 1'b0;
            stream_out_data  <= '0;
            stream_out_dest  <= '0;
            stream_out_user  <= '0;
            tlast_cnt_q      <= '0;
        end else if (handshake) begin
            stream_out_valid     <= 1'b1;
            stream_out_last      <= tlast_hit;
            stream_out_data      <= stream_in_data[grant_q];
            stream_out_dest      <= stream_in_dest[grant_q];
            stream_out_user      <= stream_in_user[grant_q];
            tlast_cnt_q[grant_q] <= tlast_hit ? 16'd0 : cur_cnt + 16'd1;
        end else if (stream_out_ready) begin
            stream_out_valid <= 1'b0;
            stream_out_last  <= 1'b0;
        end
    end

    assign grant        = grant_q;
    assign grant_active = (state_q == GRANTED);

endmodule
